vscale_hasti_rr_arbiter: RTL and testbench

VSCALE_HASTI_RR_ARBITER -- requirements
Module: vscale_hasti_rr_arbiter

---
 rtl/vscale_hasti_rr_arbiter.sv | 84 ++++++++
 tb/tb_vscale_hasti_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_rr_arbiter.sv
// vscale_hasti_rr_arbiter: shares one HASTI dmem port among NUM_CORES masters (round-robin, fixed or external grant)
module vscale_hasti_rr_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ARB_MODE = 0,
  parameter int CORE_IDX_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES*32-1:0]     core_haddr,
  input  logic [NUM_CORES-1:0]        core_hwrite,
  input  logic [NUM_CORES*3-1:0]      core_hsize,
  input  logic [NUM_CORES*3-1:0]      core_hburst,
  input  logic [NUM_CORES-1:0]        core_hmastlock,
  input  logic [NUM_CORES*4-1:0]      core_hprot,
  input  logic [NUM_CORES*2-1:0]      core_htrans,
  input  logic [NUM_CORES*32-1:0]     core_hwdata,
  output logic [NUM_CORES*32-1:0]     core_hrdata,
  output logic [NUM_CORES-1:0]        core_hready,
  output logic [NUM_CORES-1:0]        core_hresp,
  output logic [31:0]                 dmem_haddr,
  output logic                        dmem_hwrite,
  output logic [2:0]                  dmem_hsize,
  output logic [2:0]                  dmem_hburst,
  output logic                        dmem_hmastlock,
  output logic [3:0]                  dmem_hprot,
  output logic [1:0]                  dmem_htrans,
  output logic [31:0]                 dmem_hwdata,
  input  logic [31:0]                 dmem_hrdata,
  input  logic                        dmem_hready,
  input  logic                        dmem_hresp,
  input  logic [CORE_IDX_WIDTH-1:0]   next_core,
  output logic [CORE_IDX_WIDTH-1:0]   owner,
  output logic [CORE_IDX_WIDTH-1:0]   data_core,
  output logic                        data_valid
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEQ = 2'b11;
  logic [NUM_CORES-1:0] req;
  logic [CORE_IDX_WIDTH-1:0] winner;
  logic lock;
  assign dmem_haddr = core_haddr[int'(owner)*32 +: 32];
  assign dmem_hwrite = core_hwrite[owner];
  assign dmem_hsize = core_hsize[int'(owner)*3 +: 3];
  assign dmem_hburst = core_hburst[int'(owner)*3 +: 3];
  assign dmem_hmastlock = core_hmastlock[owner];
  assign dmem_hprot = core_hprot[int'(owner)*4 +: 4];
  assign dmem_htrans = core_htrans[int'(owner)*2 +: 2];
  assign dmem_hwdata = core_hwdata[int'(data_core)*32 +: 32];
  assign core_hrdata = {NUM_CORES{dmem_hrdata}};
  assign lock = (dmem_hmastlock && dmem_htrans != IDLE) || dmem_htrans == SEQ;
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++) req[i] = core_htrans[i*2 +: 2] != IDLE;
  end
  always_comb begin
    winner = owner;
    if (ARB_MODE == 2) winner = (int'(next_core) < NUM_CORES) ? next_core : owner;
    else if (ARB_MODE == 1) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) if (req[i]) winner = CORE_IDX_WIDTH'(i);
    end else begin
      for (int k = NUM_CORES; k >= 1; k--)
        if (req[(int'(owner) + k) % NUM_CORES]) winner = CORE_IDX_WIDTH'((int'(owner) + k) % NUM_CORES);
    end
  end
  always_comb begin
    core_hready = '0;
    core_hresp = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_hready[i] = (CORE_IDX_WIDTH'(i) == owner || (data_valid && CORE_IDX_WIDTH'(i) == data_core)) ? dmem_hready : !req[i];
      core_hresp[i] = (data_valid && CORE_IDX_WIDTH'(i) == data_core) ? dmem_hresp : 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= '0;
      data_core <= '0;
      data_valid <= 1'b0;
    end else if (dmem_hready) begin
      data_valid <= dmem_htrans != IDLE;
      data_core <= owner;
      if (!lock) owner <= winner;
    end
  end
endmodule

// File: tb/tb_vscale_hasti_rr_arbiter.sv
// tb_vscale_hasti_rr_arbiter: directed checks of the dmem arbiter in round-robin, fixed and external modes
module tb_vscale_hasti_rr_arbiter;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [127:0] core_haddr, core_hwdata;
  logic [3:0] core_hwrite, core_hmastlock;
  logic [11:0] core_hsize, core_hburst;
  logic [15:0] core_hprot;
  logic [7:0] core_htrans;
  logic [31:0] dmem_hrdata;
  logic dmem_hready, dmem_hresp;
  logic [1:0] next_core;
  logic [127:0] core_hrdata, fp_core_hrdata;
  logic [95:0] ex_core_hrdata;
  logic [3:0] core_hready, core_hresp, fp_core_hready, fp_core_hresp;
  logic [2:0] ex_core_hready, ex_core_hresp;
  logic [31:0] dmem_haddr, dmem_hwdata, fp_dmem_haddr, fp_dmem_hwdata, ex_dmem_haddr, ex_dmem_hwdata;
  logic dmem_hwrite, dmem_hmastlock, fp_dmem_hwrite, fp_dmem_hmastlock, ex_dmem_hwrite, ex_dmem_hmastlock;
  logic [2:0] dmem_hsize, dmem_hburst, fp_dmem_hsize, fp_dmem_hburst, ex_dmem_hsize, ex_dmem_hburst;
  logic [3:0] dmem_hprot, fp_dmem_hprot, ex_dmem_hprot;
  logic [1:0] dmem_htrans, fp_dmem_htrans, ex_dmem_htrans;
  logic [1:0] owner, data_core, fp_owner, fp_data_core, ex_owner, ex_data_core;
  logic data_valid, fp_data_valid, ex_data_valid;
  int n_chk = 0;
  int n_fail = 0;
  vscale_hasti_rr_arbiter #(.NUM_CORES(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset),
    .core_haddr(core_haddr), .core_hwrite(core_hwrite), .core_hsize(core_hsize), .core_hburst(core_hburst),
    .core_hmastlock(core_hmastlock), .core_hprot(core_hprot), .core_htrans(core_htrans), .core_hwdata(core_hwdata),
    .core_hrdata(core_hrdata), .core_hready(core_hready), .core_hresp(core_hresp),
    .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize), .dmem_hburst(dmem_hburst),
    .dmem_hmastlock(dmem_hmastlock), .dmem_hprot(dmem_hprot), .dmem_htrans(dmem_htrans), .dmem_hwdata(dmem_hwdata),
    .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .next_core(next_core), .owner(owner), .data_core(data_core), .data_valid(data_valid)
  );
  vscale_hasti_rr_arbiter #(.NUM_CORES(4), .ARB_MODE(1)) u_fp (
    .clk(clk), .reset(reset),
    .core_haddr(core_haddr), .core_hwrite(core_hwrite), .core_hsize(core_hsize), .core_hburst(core_hburst),
    .core_hmastlock(core_hmastlock), .core_hprot(core_hprot), .core_htrans(core_htrans), .core_hwdata(core_hwdata),
    .core_hrdata(fp_core_hrdata), .core_hready(fp_core_hready), .core_hresp(fp_core_hresp),
    .dmem_haddr(fp_dmem_haddr), .dmem_hwrite(fp_dmem_hwrite), .dmem_hsize(fp_dmem_hsize), .dmem_hburst(fp_dmem_hburst),
    .dmem_hmastlock(fp_dmem_hmastlock), .dmem_hprot(fp_dmem_hprot), .dmem_htrans(fp_dmem_htrans), .dmem_hwdata(fp_dmem_hwdata),
    .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .next_core(next_core), .owner(fp_owner), .data_core(fp_data_core), .data_valid(fp_data_valid)
  );
  vscale_hasti_rr_arbiter #(.NUM_CORES(3), .ARB_MODE(2)) u_ex (
    .clk(clk), .reset(reset),
    .core_haddr(core_haddr[95:0]), .core_hwrite(core_hwrite[2:0]), .core_hsize(core_hsize[8:0]), .core_hburst(core_hburst[8:0]),
    .core_hmastlock(core_hmastlock[2:0]), .core_hprot(core_hprot[11:0]), .core_htrans(core_htrans[5:0]), .core_hwdata(core_hwdata[95:0]),
    .core_hrdata(ex_core_hrdata), .core_hready(ex_core_hready), .core_hresp(ex_core_hresp),
    .dmem_haddr(ex_dmem_haddr), .dmem_hwrite(ex_dmem_hwrite), .dmem_hsize(ex_dmem_hsize), .dmem_hburst(ex_dmem_hburst),
    .dmem_hmastlock(ex_dmem_hmastlock), .dmem_hprot(ex_dmem_hprot), .dmem_htrans(ex_dmem_htrans), .dmem_hwdata(ex_dmem_hwdata),
    .dmem_hrdata(dmem_hrdata), .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .next_core(next_core), .owner(ex_owner), .data_core(ex_data_core), .data_valid(ex_data_valid)
  );
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic clear_cores;
    core_haddr = '0;
    core_hwdata = '0;
    core_hwrite = '0;
    core_hmastlock = '0;
    core_hsize = {4{3'b010}};
    core_hburst = '0;
    core_hprot = {4{4'h3}};
    core_htrans = '0;
  endtask
  task automatic drive(input int i, input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
    core_htrans[i*2 +: 2] = tr;
    core_haddr[i*32 +: 32] = a;
    core_hwrite[i] = w;
    core_hmastlock[i] = lk;
  endtask
  task automatic do_reset;
    clear_cores();
    dmem_hready = 1'b1;
    dmem_hresp = 1'b0;
    next_core = 2'd0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    clear_cores();
    core_haddr[31:0] = 32'hA0;
    core_hwrite[0] = 1'b1;
    dmem_hready = 1'b1;
    dmem_hresp = 1'b1;
    dmem_hrdata = 32'h55AA_55AA;
    next_core = 2'd0;
    step();
    step();
    n_chk++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d want 0", owner); end
    n_chk++; if (data_core !== 2'd0) begin n_fail++; $display("FAIL reset_data_core got %0d want 0", data_core); end
    n_chk++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    n_chk++; if (dmem_haddr !== 32'hA0 || dmem_hwrite !== 1'b1) begin n_fail++; $display("FAIL reset_mirror got %h/%b want 000000a0/1", dmem_haddr, dmem_hwrite); end
    n_chk++; if (core_hresp !== 4'b0000) begin n_fail++; $display("FAIL reset_hresp got %b want 0000", core_hresp); end
    n_chk++; if (core_hrdata[63:32] !== 32'h55AA_55AA) begin n_fail++; $display("FAIL reset_hrdata got %h want 55aa55aa", core_hrdata[63:32]); end
    reset = 1'b0;
    dmem_hresp = 1'b0;
  endtask
  task automatic test_single_read;
    clear_cores();
    drive(1, NS, 32'h100, 1'b0, 1'b0);
    #1;
    n_chk++; if (core_hready[1] !== 1'b0) begin n_fail++; $display("FAIL sr_wait_hready got %b want 0", core_hready[1]); end
    n_chk++; if (dmem_htrans !== IDLE) begin n_fail++; $display("FAIL sr_c0_htrans got %b want 00", dmem_htrans); end
    step();
    n_chk++; if (owner !== 2'd1 || dmem_haddr !== 32'h100 || dmem_htrans !== NS) begin n_fail++; $display("FAIL sr_grant got owner %0d addr %h trans %b want 1/00000100/10", owner, dmem_haddr, dmem_htrans); end
    n_chk++; if (fp_owner !== 2'd1) begin n_fail++; $display("FAIL sr_fp_owner got %0d want 1", fp_owner); end
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0);
    dmem_hrdata = 32'h1234_5678;
    #1;
    n_chk++; if (data_valid !== 1'b1 || data_core !== 2'd1) begin n_fail++; $display("FAIL sr_data_phase got valid %b core %0d want 1/1", data_valid, data_core); end
    n_chk++; if (core_hrdata[63:32] !== 32'h1234_5678 || core_hready[1] !== 1'b1) begin n_fail++; $display("FAIL sr_rdata got %h rdy %b want 12345678/1", core_hrdata[63:32], core_hready[1]); end
    step();
    n_chk++; if (data_valid !== 1'b0 || owner !== 2'd1) begin n_fail++; $display("FAIL sr_idle got valid %b owner %0d want 0/1", data_valid, owner); end
  endtask
  task automatic test_round_robin;
    int exp_own[5] = '{1, 2, 3, 0, 1};
    int prev = 0;
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, NS, 32'h1000 + i * 4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++; if (owner !== exp_own[k][1:0] || dmem_haddr !== 32'h1000 + exp_own[k] * 4) begin n_fail++; $display("FAIL rr_owner step %0d got %0d addr %h want %0d", k, owner, dmem_haddr, exp_own[k]); end
      n_chk++; if (data_core !== prev[1:0] || data_valid !== 1'b1) begin n_fail++; $display("FAIL rr_data_core step %0d got %0d/%b want %0d/1", k, data_core, data_valid, prev); end
      n_chk++; if (fp_owner !== 2'd0) begin n_fail++; $display("FAIL fp_owner step %0d got %0d want 0", k, fp_owner); end
      prev = exp_own[k];
    end
  endtask
  task automatic test_lock;
    do_reset();
    drive(0, NS, 32'h40, 1'b0, 1'b1);
    drive(1, NS, 32'h80, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (core_hready[1] !== 1'b0) begin n_fail++; $display("FAIL lock_hready1 step %0d got %b want 0", k, core_hready[1]); end
      step();
      n_chk++; if (owner !== 2'd0) begin n_fail++; $display("FAIL lock_owner step %0d got %0d want 0", k, owner); end
    end
    drive(0, IDLE, 32'h0, 1'b0, 1'b0);
    step();
    n_chk++; if (owner !== 2'd1) begin n_fail++; $display("FAIL lock_release got %0d want 1", owner); end
    drive(1, SEQ, 32'h84, 1'b0, 1'b0);
    drive(0, NS, 32'h44, 1'b0, 1'b0);
    step();
    n_chk++; if (owner !== 2'd1) begin n_fail++; $display("FAIL seq_hold got %0d want 1", owner); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    drive(0, NS, 32'h200, 1'b1, 1'b0);
    drive(1, NS, 32'h300, 1'b0, 1'b0);
    #1;
    n_chk++; if (dmem_hwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_write got %b want 1", dmem_hwrite); end
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0);
    core_hwdata[31:0] = 32'hDEAD_BEEF;
    core_hwdata[63:32] = 32'h0BAD_F00D;
    #1;
    n_chk++; if (owner !== 2'd1 || dmem_hwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_hwdata got owner %0d data %h want 1/deadbeef", owner, dmem_hwdata); end
    n_chk++; if (dmem_hwrite !== 1'b0 || dmem_haddr !== 32'h300) begin n_fail++; $display("FAIL b2b_read got %b/%h want 0/00000300", dmem_hwrite, dmem_haddr); end
  endtask
  task automatic test_stall;
    dmem_hready = 1'b0;
    drive(2, NS, 32'h500, 1'b0, 1'b0);
    #1;
    n_chk++; if (core_hready !== 4'b1000) begin n_fail++; $display("FAIL stall_hready got %b want 1000", core_hready); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++; if (owner !== 2'd1 || data_core !== 2'd0 || data_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold step %0d got %0d/%0d/%b want 1/0/1", k, owner, data_core, data_valid); end
    end
    dmem_hready = 1'b1;
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0);
    #1;
    n_chk++; if (owner !== 2'd2 || data_core !== 2'd1 || data_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume got %0d/%0d/%b want 2/1/1", owner, data_core, data_valid); end
  endtask
  task automatic test_error;
    dmem_hresp = 1'b1;
    dmem_hready = 1'b0;
    #1;
    n_chk++; if (core_hresp !== 4'b0010) begin n_fail++; $display("FAIL err_cycle1 got %b want 0010", core_hresp); end
    step();
    dmem_hready = 1'b1;
    #1;
    n_chk++; if (core_hresp !== 4'b0010 || core_hready[1] !== 1'b1) begin n_fail++; $display("FAIL err_cycle2 got %b rdy %b want 0010/1", core_hresp, core_hready[1]); end
    step();
    dmem_hresp = 1'b0;
  endtask
  task automatic test_ext_mode;
    do_reset();
    next_core = 2'd2;
    step();
    n_chk++; if (ex_owner !== 2'd2) begin n_fail++; $display("FAIL ex_select got %0d want 2", ex_owner); end
    next_core = 2'd3;
    step();
    n_chk++; if (ex_owner !== 2'd2) begin n_fail++; $display("FAIL ex_out_of_range got %0d want 2", ex_owner); end
    next_core = 2'd1;
    drive(1, NS, 32'h700, 1'b0, 1'b0);
    step();
    n_chk++; if (ex_owner !== 2'd1 || ex_dmem_haddr !== 32'h700) begin n_fail++; $display("FAIL ex_switch got %0d/%h want 1/00000700", ex_owner, ex_dmem_haddr); end
  endtask
  task automatic test_reset_mid;
    do_reset();
    drive(0, NS, 32'h10, 1'b0, 1'b0);
    drive(1, NS, 32'h20, 1'b0, 1'b0);
    step();
    step();
    n_chk++; if (data_core !== 2'd1 || data_valid !== 1'b1 || owner !== 2'd0) begin n_fail++; $display("FAIL rm_setup got %0d/%b/%0d want 1/1/0", data_core, data_valid, owner); end
    clear_cores();
    dmem_hresp = 1'b1;
    reset = 1'b1;
    #1;
    n_chk++; if (data_valid !== 1'b0 || data_core !== 2'd0 || owner !== 2'd0) begin n_fail++; $display("FAIL rm_async got %b/%0d/%0d want 0/0/0", data_valid, data_core, owner); end
    n_chk++; if (core_hresp !== 4'b0000 || core_hready[1] !== 1'b1) begin n_fail++; $display("FAIL rm_discard got %b rdy %b want 0000/1", core_hresp, core_hready[1]); end
    step();
    reset = 1'b0;
    dmem_hresp = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_stall();
    test_error();
    test_ext_mode();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
